uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Transmit-side scheduler that shares the single UART transmit engine between N_REQ byte-stream requesters. It also sequences configuration writes (baud/eight/pen/ohel byte) into the UART config register. It drives the UART's one-hot write strobe bus and 16-bit out_port, and paces all traffic on TXRDY. Arbitration is round-robin at packet granularity: a granted requester owns the transmitter until its last byte is accepted.

Parameters:
N_REQ, 4, number of byte-stream requesters (2..8)
LOCK_TMO, 1024, idle cycles a locked owner may hold the transmitter without req before forced release
TX_STB, 0, bit index of write[] that loads a transmit byte
CFG_STB, 6, bit index of write[] that loads the UART config register

Ports:
clk  in  1  system clock
rst  in  1  reset
req  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  N_REQ  byte presented is the final byte of the packet
ack  out  N_REQ  one-cycle pulse: byte of requester i accepted
cfg_req  in  1  configuration update request (level, held until cfg_ack)
cfg_val  in  8  new config byte: [7:4] baud_val, [3] eight, [2] pen, [1] ohel
cfg_ack  out  1  one-cycle pulse: config written
txrdy  in  1  UART transmitter ready
uart_write  out  8  one-hot write strobe bus to UART
uart_out_port  out  16  data to UART
owner  out  3  index of current packet owner (valid while locked)
locked  out  1  a packet is in progress
tmo_err  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk. Reset values: state=IDLE, all outputs 0, rr pointer=N_REQ-1 so requester 0 wins first, timeout counter 0.
- Contract with the transmitter: TXRDY is deasserted no later than 1 cycle after a write strobe. It reasserts when the engine is idle.
- States:
  - IDLE: if txrdy=0, stay. Else, if !locked and cfg_req, go to CFG_WR. Else, if locked and req[owner], go to TX_WR. Else, if !locked and any req, perform the round-robin pick and go to TX_WR. Else stay.
  - CFG_WR (1 cycle): uart_write[CFG_STB]=1, uart_out_port={8'h00,cfg_val}, cfg_ack=1. Then go to HOLD.
  - TX_WR (1 cycle): uart_write[TX_STB]=1, uart_out_port={8'h00,req_data[owner]}, ack[owner]=1. locked <= !req_last[owner]. rr pointer <= owner. Then go to HOLD.
  - HOLD (1 cycle): txrdy ignored. Then go to WAIT.
  - WAIT: stay until txrdy=1, then go to IDLE.
- Round-robin pick: search starts at pointer+1 and wraps modulo N_REQ. The first set req bit wins and is latched into owner.
- Throughput: the minimum gap between strobes is 3 cycles plus the transmitter busy time. Only one strobe bit is ever high, for exactly 1 cycle.
- Config requests are serviced only between packets (locked=0) and take priority over new packets. A config request never interleaves inside a packet.
- Lock timeout: count cycles in IDLE with locked=1, txrdy=1, and req[owner]=0. The counter clears on any TX_WR. When it reaches LOCK_TMO-1, clear locked and pulse tmo_err. The next IDLE cycle arbitrates normally.
- Simultaneous cfg_req and req with lock free: config goes first; the data request is served on the following IDLE.
- A req dropping while its byte is in TX_WR has no effect; the byte is sampled in that cycle.
- Reset mid-transfer aborts immediately; outputs return to reset values and no strobe is emitted.
- uart_out_port[15:8] is always 0. Outside strobe cycles, uart_out_port holds its last value.

Decomposition:
- Shared package: strobe index constants (TX_STB=0, CFG_STB=6, LED=1) and the state encoding (IDLE, CFG_WR, TX_WR, HOLD, WAIT).
- One sub-module: rr_arbiter (req vector, pointer in, grant index and valid out; combinational). Reusable for the receive-side distributor.

Test Plan:
1. Reset with all req=0, txrdy=1 -> uart_write=0, ack=0, locked=0 indefinitely. First req[2]=1 with data 8'h41 and last=1 -> uart_write=8'h01 with out_port=16'h0041 one cycle later, and ack[2] pulses.
2. req[0] and req[1] both held, each single-byte (last=1), txrdy modelled at 10 busy cycles -> grants alternate 0,1,0,1. ack pulses are separated by 13 cycles.
3. req[1] sends 3-byte packet (8'h10, 8'h11, 8'h12, last on the third) while req[3] is continuously asserted -> three consecutive acks to requester 1 before any ack[3]. locked falls after byte 8'h12.
4. cfg_req with cfg_val=8'h5A raised during packet byte 2 of 3 -> cfg strobe uart_write=8'h40, out_port=16'h005A, issued only after the last byte. cfg_ack is 1 cycle.
5. Owner drops req mid-packet with LOCK_TMO=16 -> tmo_err pulses after 16 idle cycles, locked=0, and the next requester is granted.
6. Assert rst during WAIT -> all outputs 0 asynchronously. After release, requester 0 wins the first arbitration.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
//   Shared definitions for the UART transmit scheduler.
//   - Bit positions of the UART one-hot write strobe bus.
//   - Scheduler state encoding.
//   - Round-robin index step helper. It is shared with the receive-side distributor.
package uart_tx_sched_pkg;

    localparam int unsigned STB_TX  = 0;  // write[] bit that loads a transmit byte
    localparam int unsigned STB_LED = 1;  // write[] bit of the LED register (not driven here)
    localparam int unsigned STB_CFG = 6;  // write[] bit that loads the UART config register

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        TX_WR,
        HOLD,
        WAIT
    } sched_state_t;

    // Next index after cur, wrapping modulo n.
    function automatic logic [2:0] rr_next(input logic [2:0] cur, input int unsigned n);
        return (32'(cur) + 32'd1 >= n) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Bundles the requester, config, and UART-side signals of the transmit scheduler.
//   master : requesters / config source / UART ready (drives req*, cfg_req, cfg_val, txrdy)
//   slave  : the scheduler (drives ack, cfg_ack, uart_write, uart_out_port,
//            owner, locked, tmo_err)
interface uart_tx_sched_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;
    logic               cfg_req;
    logic [7:0]         cfg_val;
    logic               cfg_ack;
    logic               txrdy;
    logic [7:0]         uart_write;
    logic [15:0]        uart_out_port;
    logic [2:0]         owner;
    logic               locked;
    logic               tmo_err;

    modport master (
        output req, req_data, req_last, cfg_req, cfg_val, txrdy,
        input  ack, cfg_ack, uart_write, uart_out_port, owner, locked, tmo_err
    );

    modport slave (
        input  req, req_data, req_last, cfg_req, cfg_val, txrdy,
        output ack, cfg_ack, uart_write, uart_out_port, owner, locked, tmo_err
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// uart_tx_sched_rr_arbiter
//   Combinational round-robin pick.
//   The search starts one past ptr and wraps modulo N_REQ.
//   The first set request bit wins.
//   req   : request vector
//   ptr   : index of the previous winner
//   grant : winning index (valid only when valid=1)
//   valid : at least one request is set
module uart_tx_sched_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       grant,
    output logic             valid
);

    logic [7:0] req8;
    logic [2:0] cand;

    always_comb begin
        req8  = 8'(req);
        grant = '0;
        valid = 1'b0;
        cand  = ptr;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = rr_next(cand, N_REQ);
            if (!valid && req8[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART transmit engine between N_REQ byte-stream requesters.
//   Arbitration is round-robin at packet granularity.
//   The scheduler also sequences UART config-register writes between packets.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : uart_tx_sched_if.slave with the following signal groups:
//                - requester handshake: req, req_data, req_last, ack
//                - config handshake: cfg_req, cfg_val, cfg_ack
//                - UART side: txrdy, uart_write, uart_out_port
//                - status: owner, locked, tmo_err
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned LOCK_TMO = 1024,
    parameter int unsigned TX_STB   = STB_TX,
    parameter int unsigned CFG_STB  = STB_CFG
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    localparam logic [7:0]  TX_MASK  = 8'(1 << TX_STB);
    localparam logic [7:0]  CFG_MASK = 8'(1 << CFG_STB);
    localparam int unsigned TMO_W    = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TMO - 1);

    sched_state_t     state;
    logic [2:0]       owner_q;
    logic [2:0]       ptr_q;
    logic             locked_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       write_q;
    logic [15:0]      port_q;
    logic [N_REQ-1:0] ack_q;
    logic             cfg_ack_q;
    logic             tmo_err_q;

    logic [2:0]       grant;
    logic             grant_valid;
    logic [2:0]       sel;
    logic             sel_req;
    logic             sel_last;
    logic [7:0]       sel_byte;
    logic [N_REQ-1:0] sel_onehot;
    logic             cfg_go;
    logic             tx_go;

    uart_tx_sched_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    // While locked the owner keeps the transmitter; otherwise the arbiter's pick is used.
    always_comb begin
        sel        = locked_q ? owner_q : grant;
        sel_req    = 1'b0;
        sel_last   = 1'b0;
        sel_byte   = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (3'(i) == sel) begin
                sel_req       = bus.req[i];
                sel_last      = bus.req_last[i];
                sel_byte      = bus.req_data[8*i +: 8];
                sel_onehot[i] = 1'b1;
            end
        end
        cfg_go = bus.txrdy && !locked_q && bus.cfg_req;
        tx_go  = bus.txrdy && !cfg_go && (locked_q ? sel_req : grant_valid);
    end

    // Strobe, ack and data registers are loaded on the edge leaving IDLE.
    // As a result they are high exactly during the CFG_WR/TX_WR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_q   <= '0;
            ptr_q     <= 3'(N_REQ - 1);
            locked_q  <= 1'b0;
            tmo_cnt   <= '0;
            write_q   <= '0;
            port_q    <= '0;
            ack_q     <= '0;
            cfg_ack_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            write_q   <= '0;
            ack_q     <= '0;
            cfg_ack_q <= 1'b0;
            tmo_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_go) begin
                        state     <= CFG_WR;
                        write_q   <= CFG_MASK;
                        port_q    <= {8'h00, bus.cfg_val};
                        cfg_ack_q <= 1'b1;
                    end else if (tx_go) begin
                        state    <= TX_WR;
                        owner_q  <= sel;
                        ptr_q    <= sel;
                        locked_q <= !sel_last;
                        write_q  <= TX_MASK;
                        port_q   <= {8'h00, sel_byte};
                        ack_q    <= sel_onehot;
                        tmo_cnt  <= '0;
                    end else if (bus.txrdy && locked_q) begin
                        // Reaching this branch implies the owner is not requesting.
                        if (tmo_cnt == TMO_LAST) begin
                            locked_q  <= 1'b0;
                            tmo_err_q <= 1'b1;
                            tmo_cnt   <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                CFG_WR, TX_WR: state <= HOLD;
                HOLD:          state <= WAIT;
                WAIT:          if (bus.txrdy) state <= IDLE;
                default:       state <= IDLE;
            endcase
        end
    end

    assign bus.uart_write    = write_q;
    assign bus.uart_out_port = port_q;
    assign bus.ack           = ack_q;
    assign bus.cfg_ack       = cfg_ack_q;
    assign bus.owner         = owner_q;
    assign bus.locked        = locked_q;
    assign bus.tmo_err       = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched.
//   It uses N_REQ=4 and LOCK_TMO=16.
//   The UART model drops txrdy on the cycle after a strobe and holds it low for BUSY cycles.
//   Stimulus is driven and outputs are sampled on the falling clock edge.
module tb_uart_tx_sched;
    localparam int unsigned N    = 4;
    localparam int unsigned BUSY = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned busy_cnt = 0;

    int unsigned idle_bad, n, n1, stray, ta, tt, cfg_cycles;
    logic [31:0] ack_v [4];
    logic [31:0] ack_t [4];
    logic [31:0] ack_p [4];
    logic [31:0] exp_v [4];
    logic [31:0] exp_p [4];
    logic [31:0] ev_wr [5];
    logic [31:0] ev_port [5];
    logic [31:0] ev_ack [5];
    logic [31:0] ev_cack [5];
    logic [31:0] ev_lock [5];
    logic [31:0] x_wr [5];
    logic [31:0] x_port [5];
    logic [31:0] x_ack [5];
    logic [31:0] x_cack [5];
    logic [31:0] x_lock [5];

    uart_tx_sched_if #(.N_REQ(N)) bus ();

    uart_tx_sched #(.N_REQ(N), .LOCK_TMO(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for cycles 1..BUSY after the strobe cycle.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt  = 0;
            bus.txrdy = 1'b1;
        end else if (bus.uart_write != 0) begin
            busy_cnt = BUSY;
        end else if (busy_cnt > 0) begin
            bus.txrdy = 1'b0;
            busy_cnt--;
        end else begin
            bus.txrdy = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int unsigned idx, output int unsigned at);
        at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ack[idx[1:0]]) begin
                at = cyc;
                return;
            end
        end
        check("ack_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.cfg_req  = 1'b0;
        bus.cfg_val  = '0;

        // 1: reset values, idle quiet, first grant.
        repeat (3) @(negedge clk);
        check("rst_write",  32'(bus.uart_write), 32'h0);
        check("rst_port",   32'(bus.uart_out_port), 32'h0);
        check("rst_ack",    32'(bus.ack), 32'h0);
        check("rst_locked", 32'(bus.locked), 32'h0);
        check("rst_owner",  32'(bus.owner), 32'h0);
        check("rst_cfgack", 32'(bus.cfg_ack), 32'h0);
        check("rst_tmo",    32'(bus.tmo_err), 32'h0);
        rst = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.uart_write != 0 || bus.ack != 0 || bus.locked) idle_bad++;
        end
        check("idle_quiet", idle_bad, 32'h0);
        bus.req_data[23:16] = 8'h41;
        bus.req_last[2]     = 1'b1;
        bus.req[2]          = 1'b1;
        @(negedge clk);
        check("t1_write", 32'(bus.uart_write), 32'h01);
        check("t1_port",  32'(bus.uart_out_port), 32'h0041);
        check("t1_ack",   32'(bus.ack), 32'h4);
        bus.req[2] = 1'b0;
        @(negedge clk);
        check("t1_write_pulse", 32'(bus.uart_write), 32'h0);
        check("t1_ack_pulse",   32'(bus.ack), 32'h0);
        check("t1_port_hold",   32'(bus.uart_out_port), 32'h0041);
        check("t1_locked",      32'(bus.locked), 32'h0);
        repeat (20) @(negedge clk);

        // 2: two single-byte requesters alternate, 13 cycles apart.
        bus.req_data[7:0]  = 8'hA0;
        bus.req_data[15:8] = 8'hA1;
        bus.req_last[1:0]  = 2'b11;
        bus.req[1:0]       = 2'b11;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            ack_v[k] = '0; ack_t[k] = '0; ack_p[k] = '0;
        end
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                ack_v[n] = 32'(bus.ack);
                ack_t[n] = cyc;
                ack_p[n] = 32'(bus.uart_out_port);
                n++;
            end
        end
        bus.req = '0;
        check("t2_count", n, 32'd4);
        exp_v = '{32'h1, 32'h2, 32'h1, 32'h2};
        exp_p = '{32'hA0, 32'hA1, 32'hA0, 32'hA1};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_grant%0d", k), ack_v[k], exp_v[k]);
            check($sformatf("t2_port%0d", k),  ack_p[k], exp_p[k]);
        end
        for (int k = 1; k < 4; k++)
            check($sformatf("t2_gap%0d", k), ack_t[k] - ack_t[k-1], 32'd13);
        repeat (20) @(negedge clk);

        // 3+4: three-byte packet from 1 with 3 waiting and config raised mid-packet.
        bus.req_data[15:8] = 8'h10;
        bus.req_last[1]    = 1'b0;
        bus.req[1]         = 1'b1;
        n = 0; n1 = 0; cfg_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            ev_wr[k] = '0; ev_port[k] = '0; ev_ack[k] = '0; ev_cack[k] = '0; ev_lock[k] = '0;
        end
        for (int c = 0; c < 300 && n < 5; c++) begin
            @(negedge clk);
            if (bus.cfg_ack) cfg_cycles++;
            if (bus.uart_write != 0) begin
                ev_wr[n]   = 32'(bus.uart_write);
                ev_port[n] = 32'(bus.uart_out_port);
                ev_ack[n]  = 32'(bus.ack);
                ev_cack[n] = 32'(bus.cfg_ack);
                ev_lock[n] = 32'(bus.locked);
                n++;
                if (bus.ack[1]) begin
                    n1++;
                    if (n1 == 1) begin
                        bus.req_data[15:8]  = 8'h11;
                        bus.req_data[31:24] = 8'h33;
                        bus.req_last[3]     = 1'b1;
                        bus.req[3]          = 1'b1;
                    end else if (n1 == 2) begin
                        bus.req_data[15:8] = 8'h12;
                        bus.req_last[1]    = 1'b1;
                        bus.cfg_val        = 8'h5A;
                        bus.cfg_req        = 1'b1;
                    end else begin
                        bus.req[1] = 1'b0;
                    end
                end
                if (bus.cfg_ack) bus.cfg_req = 1'b0;
                if (bus.ack[3])  bus.req[3]  = 1'b0;
            end
        end
        @(negedge clk);
        if (bus.cfg_ack) cfg_cycles++;
        check("t3_events", n, 32'd5);
        x_wr   = '{32'h01, 32'h01, 32'h01, 32'h40, 32'h01};
        x_port = '{32'h10, 32'h11, 32'h12, 32'h5A, 32'h33};
        x_ack  = '{32'h2, 32'h2, 32'h2, 32'h0, 32'h8};
        x_cack = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0};
        x_lock = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_write%0d", k),  ev_wr[k],   x_wr[k]);
            check($sformatf("t3_port%0d", k),   ev_port[k], x_port[k]);
            check($sformatf("t3_ack%0d", k),    ev_ack[k],  x_ack[k]);
            check($sformatf("t3_cfgack%0d", k), ev_cack[k], x_cack[k]);
            check($sformatf("t3_locked%0d", k), ev_lock[k], x_lock[k]);
        end
        check("t4_cfgack_cycles", cfg_cycles, 32'd1);
        repeat (20) @(negedge clk);

        // 5: owner abandons its packet; forced release after 16 idle cycles.
        bus.req_data[7:0] = 8'h50;
        bus.req_last[0]   = 1'b0;
        bus.req[0]        = 1'b1;
        wait_ack(0, ta);
        check("t5_locked", 32'(bus.locked), 32'h1);
        check("t5_owner",  32'(bus.owner), 32'h0);
        bus.req[0]          = 1'b0;
        bus.req_data[23:16] = 8'h52;
        bus.req_last[2]     = 1'b1;
        bus.req[2]          = 1'b1;
        tt = 0; stray = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.tmo_err) begin
                tt = cyc;
                break;
            end
            if (bus.uart_write != 0) stray++;
        end
        check("t5_tmo_delay",  tt - ta, 32'd28);
        check("t5_no_strobe",  stray, 32'd0);
        check("t5_unlocked",   32'(bus.locked), 32'h0);
        @(negedge clk);
        check("t5_tmo_pulse",  32'(bus.tmo_err), 32'h0);
        check("t5_next_ack",   32'(bus.ack), 32'h4);
        check("t5_next_port",  32'(bus.uart_out_port), 32'h52);
        bus.req[2] = 1'b0;
        repeat (20) @(negedge clk);

        // 6: asynchronous reset while waiting on the transmitter.
        bus.req_data[31:24] = 8'h77;
        bus.req_last[3]     = 1'b0;
        bus.req[3]          = 1'b1;
        wait_ack(3, ta);
        bus.req[3] = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_pre_locked", 32'(bus.locked), 32'h1);
        check("t6_pre_owner",  32'(bus.owner), 32'h3);
        rst = 1'b1;
        #1;
        check("t6_rst_write",  32'(bus.uart_write), 32'h0);
        check("t6_rst_port",   32'(bus.uart_out_port), 32'h0);
        check("t6_rst_owner",  32'(bus.owner), 32'h0);
        check("t6_rst_locked", 32'(bus.locked), 32'h0);
        check("t6_rst_ack",    32'(bus.ack), 32'h0);
        repeat (2) @(negedge clk);
        bus.req_data[7:0]   = 8'h0F;
        bus.req_data[31:24] = 8'h3F;
        bus.req_last[0]     = 1'b1;
        bus.req_last[3]     = 1'b1;
        bus.req[0]          = 1'b1;
        bus.req[3]          = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_first_write", 32'(bus.uart_write), 32'h01);
        check("t6_first_ack",   32'(bus.ack), 32'h1);
        check("t6_first_port",  32'(bus.uart_out_port), 32'h0F);
        bus.req = '0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
